// File: rtl/mult_pipe.sv
// Fully pipelined WIDTH x WIDTH integer multiplier for the execute-stage multiply unit.
// Supports MUL/MULH/MULHSU/MULHU, global stall on output backpressure, and single-cycle flush.
module mult_pipe #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned STAGES = 8,
  parameter int unsigned TAG_W  = 6
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  output logic             in_ready,
  input  logic [1:0]       func,
  input  logic [WIDTH-1:0] mcand_in,
  input  logic [WIDTH-1:0] mplier_in,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             flush,
  input  logic             out_ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [TAG_W-1:0] tag_out
);

  localparam int unsigned K  = WIDTH / STAGES;
  localparam int unsigned PW = 2 * WIDTH;

  localparam logic [1:0] FnMul    = 2'b00;
  localparam logic [1:0] FnMulh   = 2'b01;
  localparam logic [1:0] FnMulhsu = 2'b10;

  logic [STAGES-1:0]                valid_d, valid_q;
  logic [STAGES-1:0][1:0]           func_d, func_q;
  logic [STAGES-1:0][TAG_W-1:0]     tag_d, tag_q;
  logic [STAGES-1:0]                neg_d, neg_q;
  logic [STAGES-1:0][PW-1:0]        part_d, part_q;
  logic [STAGES-1:0][PW-1:0]        mcand_d, mcand_q;
  logic [STAGES-1:0][WIDTH-1:0]     mplier_d, mplier_q;

  logic             done_d, done_q;
  logic [WIDTH-1:0] result_d, result_q;
  logic [TAG_W-1:0] tag_out_d, tag_out_q;

  logic             stall, accept;
  logic             a_signed, b_signed, a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [PW-1:0]    prod;

  // One radix-2^K partial product: K multiplier bits times the shifted multiplicand.
  function automatic logic [PW-1:0] step_pp(input logic [K-1:0] m, input logic [PW-1:0] c);
    logic [PW-1:0] mz;
    mz        = '0;
    mz[K-1:0] = m;
    return mz * c;
  endfunction

  // Stage 0: magnitudes and result sign; MUL is treated as unsigned.
  always_comb begin
    a_signed = (func == FnMulh) || (func == FnMulhsu);
    b_signed = (func == FnMulh);
    a_neg    = a_signed && mcand_in[WIDTH-1];
    b_neg    = b_signed && mplier_in[WIDTH-1];
    mag_a    = a_neg ? -mcand_in : mcand_in;
    mag_b    = b_neg ? -mplier_in : mplier_in;
  end

  always_comb begin
    stall    = done_q && !out_ready;
    accept   = start && !stall && !flush;
    in_ready = !stall;

    valid_d   = valid_q;
    func_d    = func_q;
    tag_d     = tag_q;
    neg_d     = neg_q;
    part_d    = part_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    done_d    = done_q;
    result_d  = result_q;
    tag_out_d = tag_out_q;

    prod = part_q[STAGES-1] + step_pp(mplier_q[STAGES-1][K-1:0], mcand_q[STAGES-1]);
    if (neg_q[STAGES-1]) begin
      prod = -prod;
    end

    if (!stall) begin
      valid_d[0]  = accept;
      func_d[0]   = func;
      tag_d[0]    = tag_in;
      neg_d[0]    = a_neg ^ b_neg;
      part_d[0]   = '0;
      mcand_d[0]  = {{WIDTH{1'b0}}, mag_a};
      mplier_d[0] = mag_b;
      for (int i = 1; i < STAGES; i++) begin
        valid_d[i]  = valid_q[i-1];
        func_d[i]   = func_q[i-1];
        tag_d[i]    = tag_q[i-1];
        neg_d[i]    = neg_q[i-1];
        part_d[i]   = part_q[i-1] + step_pp(mplier_q[i-1][K-1:0], mcand_q[i-1]);
        mplier_d[i] = mplier_q[i-1] >> K;
        mcand_d[i]  = mcand_q[i-1] << K;
      end
      done_d = valid_q[STAGES-1];
      if (valid_q[STAGES-1]) begin
        result_d  = (func_q[STAGES-1] == FnMul) ? prod[WIDTH-1:0] : prod[PW-1:WIDTH];
        tag_out_d = tag_q[STAGES-1];
      end
    end

    // Flush wins over stall; datapath contents are left as-is.
    if (flush) begin
      valid_d = '0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q   <= '0;
      func_q    <= '0;
      tag_q     <= '0;
      neg_q     <= '0;
      part_q    <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      done_q    <= 1'b0;
      result_q  <= '0;
      tag_out_q <= '0;
    end else begin
      valid_q   <= valid_d;
      func_q    <= func_d;
      tag_q     <= tag_d;
      neg_q     <= neg_d;
      part_q    <= part_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      done_q    <= done_d;
      result_q  <= result_d;
      tag_out_q <= tag_out_d;
    end
  end

  assign done    = done_q;
  assign result  = result_q;
  assign tag_out = tag_out_q;

endmodule

// File: tb/tb_mult_pipe.sv
// Directed-vector bench for mult_pipe: sign modes, latency, streaming, backpressure,
// flush and asynchronous reset with hand-computed expected values.
module tb_mult_pipe;

  localparam logic [1:0] FnMul    = 2'b00;
  localparam logic [1:0] FnMulh   = 2'b01;
  localparam logic [1:0] FnMulhsu = 2'b10;
  localparam logic [1:0] FnMulhu  = 2'b11;

  logic        clock, reset_n, start, in_ready, flush, out_ready, done;
  logic [1:0]  func;
  logic [63:0] mcand_in, mplier_in, result;
  logic [5:0]  tag_in, tag_out;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [63:0] cap_res[$];
  logic [5:0]  cap_tag[$];
  int          cap_cyc[$];

  mult_pipe #(
    .WIDTH (64),
    .STAGES(8),
    .TAG_W (6)
  ) u_dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .in_ready (in_ready),
    .func     (func),
    .mcand_in (mcand_in),
    .mplier_in(mplier_in),
    .tag_in   (tag_in),
    .flush    (flush),
    .out_ready(out_ready),
    .done     (done),
    .result   (result),
    .tag_out  (tag_out)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  // Record every result the consumer takes (sampled mid-cycle, inputs are stable).
  always @(negedge clock) begin
    if (reset_n && done && out_ready) begin
      cap_res.push_back(result);
      cap_tag.push_back(tag_out);
      cap_cyc.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [1:0] f, input logic [63:0] a, input logic [63:0] b,
                       input logic [5:0] t);
    start     = 1'b1;
    func      = f;
    mcand_in  = a;
    mplier_in = b;
    tag_in    = t;
  endtask

  task automatic clear_cap();
    cap_res.delete();
    cap_tag.delete();
    cap_cyc.delete();
  endtask

  task automatic run_one(input string name, input logic [1:0] f, input logic [63:0] a,
                         input logic [63:0] b, input logic [5:0] t, input logic [63:0] exp);
    int lat;
    drive(f, a, b, t);
    tick();
    start = 1'b0;
    lat   = 0;
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
    check_eq({name, "_lat"}, lat, 8);
    check_eq({name, "_res"}, result, exp);
    check_eq({name, "_tag"}, tag_out, t);
    tick();
    check_eq({name, "_done_fall"}, done, 0);
  endtask

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    func      = 2'b00;
    mcand_in  = '0;
    mplier_in = '0;
    tag_in    = '0;

    #12;
    check_eq("rst_done", done, 0);
    check_eq("rst_result", result, 0);
    check_eq("rst_tag", tag_out, 0);
    check_eq("rst_in_ready", in_ready, 1);
    reset_n = 1'b1;
    tick();

    // Single operations across all sign modes.
    run_one("mul_3x5", FnMul, 64'd3, 64'd5, 6'h2A, 64'd15);
    run_one("mul_ovf", FnMul, 64'h8000_0000_0000_0000, 64'd2, 6'h01, 64'd0);
    run_one("mulh_m1", FnMulh, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 6'h02, 64'd0);
    run_one("mulhu_max", FnMulhu, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 6'h03,
            64'hFFFF_FFFF_FFFF_FFFE);
    run_one("mulhsu_neg", FnMulhsu, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 6'h04,
            64'hFFFF_FFFF_FFFF_FFFF);
    run_one("mul_neg", FnMul, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 6'h05, 64'hFFFF_FFFF_FFFF_FFFA);
    run_one("mulh_minmin", FnMulh, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 6'h06,
            64'h4000_0000_0000_0000);
    run_one("mulh_neg", FnMulh, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 6'h07, 64'hFFFF_FFFF_FFFF_FFFF);

    // Back-to-back stream of n*(n+1).
    clear_cap();
    for (int n = 1; n <= 8; n++) begin
      drive(FnMul, 64'(n), 64'(n + 1), 6'(n));
      tick();
    end
    start = 1'b0;
    for (int w = 0; w < 30 && cap_res.size() < 8; w++) tick();
    tick();
    tick();
    check_eq("b2b_count", cap_res.size(), 8);
    for (int j = 0; j < 8; j++) begin
      if (j < cap_res.size()) begin
        check_eq($sformatf("b2b_res%0d", j), cap_res[j], 64'((j + 1) * (j + 2)));
        check_eq($sformatf("b2b_tag%0d", j), cap_tag[j], 64'(j + 1));
        check_eq($sformatf("b2b_cyc%0d", j), cap_cyc[j], cap_cyc[0] + j);
      end
    end

    // Backpressure: fill the pipe with out_ready low, then stall three cycles.
    clear_cap();
    out_ready = 1'b0;
    for (int n = 1; n <= 9; n++) begin
      drive(FnMul, 64'(n), 64'd3, 6'(16 + n));
      tick();
    end
    check_eq("bp_done", done, 1);
    drive(FnMul, 64'd100, 64'd100, 6'h3F);
    for (int s = 0; s < 4; s++) begin
      check_eq($sformatf("bp_in_ready%0d", s), in_ready, 0);
      check_eq($sformatf("bp_res%0d", s), result, 64'd3);
      check_eq($sformatf("bp_tag%0d", s), tag_out, 64'h11);
      if (s < 3) tick();
    end
    start     = 1'b0;
    out_ready = 1'b1;
    for (int w = 0; w < 30 && cap_res.size() < 9; w++) tick();
    for (int w = 0; w < 12; w++) tick();
    check_eq("bp_count", cap_res.size(), 9);
    for (int j = 0; j < 9; j++) begin
      if (j < cap_res.size()) begin
        check_eq($sformatf("bp_out_res%0d", j), cap_res[j], 64'((j + 1) * 3));
        check_eq($sformatf("bp_out_tag%0d", j), cap_tag[j], 64'(17 + j));
      end
    end

    // Flush mid-stream with a same-cycle start, then a fresh op right after.
    clear_cap();
    for (int n = 0; n < 4; n++) begin
      drive(FnMul, 64'd5, 64'(n + 1), 6'(32 + n));
      tick();
    end
    drive(FnMul, 64'd5, 64'd5, 6'h24);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    run_one("post_flush", FnMul, 64'd7, 64'd9, 6'h30, 64'd63);
    for (int w = 0; w < 5; w++) tick();
    check_eq("flush_count", cap_res.size(), 1);
    if (cap_tag.size() > 0) check_eq("flush_tag", cap_tag[0], 64'h30);

    // Asynchronous reset with a stalled result and four ops behind it.
    clear_cap();
    out_ready = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      drive(FnMul, 64'(n), 64'd11, 6'(n));
      tick();
    end
    start = 1'b0;
    for (int w = 0; w < 20 && !done; w++) tick();
    check_eq("rst_pre_done", done, 1);
    check_eq("rst_pre_res", result, 64'd11);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("rst_mid_done", done, 0);
    check_eq("rst_mid_res", result, 0);
    check_eq("rst_mid_tag", tag_out, 0);
    check_eq("rst_mid_in_ready", in_ready, 1);
    #2;
    reset_n   = 1'b1;
    out_ready = 1'b1;
    for (int w = 0; w < 15; w++) tick();
    check_eq("rst_stale_count", cap_res.size(), 0);
    check_eq("rst_post_done", done, 0);
    check_eq("rst_post_in_ready", in_ready, 1);
    run_one("post_rst", FnMulhu, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 6'h15, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mult_pipe.md
# mult_pipe

Parametrised, fully pipelined integer multiplier for the execute stage's multiply functional unit. It accepts one operation per cycle and supports signed, unsigned and mixed-sign operands. It returns either the low or high WIDTH bits of the 2×WIDTH product, with a tag carried alongside. The pipeline stalls globally on output backpressure and supports a single-cycle flush for branch-mispredict recovery.

## Interface
- WIDTH, 64, operand and result width.
- STAGES, 8, pipeline depth; WIDTH % STAGES == 0 is required; each stage retires WIDTH/STAGES multiplier bits.
- TAG_W, 6, width of the ROB/RS tag carried with each operation.
- clock  input  1  single clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  operation valid this cycle.
- in_ready  output  1  unit can accept; combinational, equal to !(done && !out_ready).
- func  input  2  operation: 00 MUL (low half), 01 MULH (s×s, high), 10 MULHSU (s×u, high), 11 MULHU (u×u, high).
- mcand_in  input  WIDTH  multiplicand, rs1.
- mplier_in  input  WIDTH  multiplier, rs2.
- tag_in  input  TAG_W  tag for the operation.
- flush  input  1  kill all in-flight operations.
- out_ready  input  1  consumer accepts the result this cycle.
- done  output  1  result valid.
- result  output  WIDTH  selected product half.
- tag_out  output  TAG_W  tag of the result.

## Operation
- **Accept:** an operation is accepted when start && in_ready && !flush.
- **Stage 0 (sign handling):** for signed operands, take |mcand| and |mplier|. neg = sign(mcand) XOR sign(mplier), restricted to operands treated as signed by func.
  - MUL treats both operands as unsigned; the low half is sign-agnostic.
- **Per stage:** each stage registers a valid bit, func, tag, neg, the partial product (2×WIDTH), the shifted multiplier and the shifted multiplicand.
  - partial += mplier[WIDTH/STAGES-1:0] × mcand.
  - Shift the multiplier right and the multiplicand left by WIDTH/STAGES.
- **Final stage:** if neg, take the two's complement of the full 2×WIDTH product. Select product[WIDTH-1:0] for MUL and product[2W-1:W] otherwise.
- **Output register:** result, tag_out and done are registered outputs of the final stage.
- **Stall:**
  - When done && !out_ready, every stage register, including the outputs, holds its value.
  - in_ready is low in that cycle and start is ignored.
  - Stall is global; bubbles are not compressed.
- **Flush:**
  - On a cycle with flush=1, every valid bit, including done, clears at the next edge, regardless of stall.
  - A same-cycle start is dropped.
  - Datapath registers need not clear.
- **Reset:** while reset_n=0, every valid bit and done are 0, and result and tag_out are 0. This applies immediately, mid-operation included.
- **Ordering:** results leave in acceptance order; there is no reordering.

## Timing
- **Latency:** an operation accepted at edge k produces done=1 with its result after edge k+STAGES (8 cycles at the default), assuming no stall.
- **Throughput:** one operation per cycle while out_ready=1.
- **Result hold:** a result is consumed at the edge where done && out_ready. If no new result arrives behind it, done falls after that edge.
- **Stall cost:** each stall cycle adds exactly one cycle to the latency of every in-flight operation.
- **Flush then start:** flush at cycle c with start at c+1 is accepted normally; its done arrives at c+1+STAGES.
- **Reset release:** the first accept is possible on the first edge with reset_n=1. in_ready=1 out of reset.
- **Simultaneous flush and out_ready:** the result presented in that cycle is still consumed; the consumer must ignore its tag per the flush owner.

## Test plan
- **MUL basic:** MUL 3×5, tag 0x2A, out_ready=1 -> done exactly 8 cycles later, result=15, tag_out=0x2A. MUL 0x8000_0000_0000_0000×2 -> result 0.
- **Sign modes:** with mcand=mplier=0xFFFF_FFFF_FFFF_FFFF, MULH -> 0 and MULHU -> 0xFFFF_FFFF_FFFF_FFFE. MULHSU with mcand=−2, mplier=3 -> 0xFFFF_FFFF_FFFF_FFFF. MUL with −2×3 -> 0xFFFF_FFFF_FFFF_FFFA.
- **Back-to-back:** 8 consecutive operations n×(n+1), n=1..8, tags 1..8 -> done high for 8 consecutive cycles, results 2,6,12,…,72 in tag order.
- **Backpressure:** fill the pipe, then hold out_ready=0 for 3 cycles -> in_ready=0, result/tag_out stable, no start accepted. After release, all results are delivered in order with none lost or duplicated.
- **Flush:** issue 4 operations, assert flush one cycle mid-stream with start=1 -> no done for any of those operations, including the one offered with flush. A new operation on the following cycle completes 8 cycles later with a correct result.
- **Reset mid-operation:** pulse reset_n low asynchronously between edges with 5 operations in flight -> done, result and tag_out go to 0 immediately; no stale done after release; in_ready=1.
